// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT datapath.
//
// Contents:
//   FFT_LOG2_NS, FFT_NS, FFT_DW : default frame geometry and component width,
//                                 shared by the framer and the FFT core
//   IDX_MAX_W                   : widest index bitrev() can handle
//   cplx_t                      : packed complex sample {re, im}, signed
//   bitrev()                    : reverse the low `width` bits of an index
package fft_pkg;

  localparam int unsigned FFT_LOG2_NS = 3;
  localparam int unsigned FFT_NS      = 1 << FFT_LOG2_NS;
  localparam int unsigned FFT_DW      = 16;
  localparam int unsigned IDX_MAX_W   = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  // Reverse all IDX_MAX_W bits with constant indices, then shift the
  // reversed field down so only the low `width` bits remain.
  function automatic logic [IDX_MAX_W-1:0] bitrev(input logic [IDX_MAX_W-1:0] idx,
                                                  input int unsigned          width);
    logic [IDX_MAX_W-1:0] full_rev;
    full_rev = '0;
    for (int i = 0; i < IDX_MAX_W; i++) begin
      full_rev[i] = idx[IDX_MAX_W-1-i];
    end
    return full_rev >> (IDX_MAX_W - width);
  endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One ping-pong bank: NS complex entries plus the flag that marks the bank
// as holding a complete frame.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears flag and storage)
//   wr_en      : write wr_data into entry wr_addr
//   wr_addr    : write index (natural order)
//   wr_data    : complex sample to store
//   set_full   : bank now holds a complete frame
//   clr_full   : last sample of the frame has been read out
//   rd_addr    : read index (asynchronous read)
//   rd_data    : entry at rd_addr
//   full       : bank holds a complete, not yet drained frame
module fft_pp_bank
  import fft_pkg::*;
#(
  parameter int unsigned LOG2_NS = FFT_LOG2_NS,
  parameter int unsigned NS      = FFT_NS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [LOG2_NS-1:0] wr_addr,
  input  cplx_t              wr_data,
  input  logic               set_full,
  input  logic               clr_full,
  input  logic [LOG2_NS-1:0] rd_addr,
  output cplx_t              rd_data,
  output logic               full
);

  cplx_t mem_q [NS];
  cplx_t mem_d [NS];
  logic  full_q;
  logic  full_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    mem_d  = mem_q;
    full_d = full_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    if (set_full) begin
      full_d = 1'b1;
    end else if (clr_full) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from the same edge, independent of order.
    if (!rst_n) begin
      // NOTE: storage is reset too, so a frame cut short by reset can never
      // surface stale samples; this keeps the bank in flops, not a RAM macro.
      mem_q  <= '{default: '0};
      full_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      full_q <= full_d;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign full    = full_q;

  // The writer and reader are always on different banks while both are
  // active, so one bank can never be filled and drained in the same cycle.
  a_no_set_clr : assert property (@(posedge clk) disable iff (!rst_n)
    !(set_full && clr_full));

endmodule

// File: rtl/fft_bitrev_framer.sv
// Input framer for the radix-2 DIT FFT core. Collects NS complex samples
// into one of two ping-pong banks and replays each completed frame in
// bit-reversed index order while the other bank is filled.
//
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   in_re, in_im      : input sample (signed), qualified by in_valid
//   in_valid/in_ready : input handshake; in_ready depends on state only
//   out_re, out_im    : output sample, bit-exact copy of the stored input
//   out_index         : natural (pre-reversal) index of the output sample
//   out_last          : final sample of the frame
//   out_valid/out_ready : output handshake; outputs hold while stalled
module fft_bitrev_framer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2_NS = FFT_LOG2_NS,
  parameter int unsigned NS      = FFT_NS,
  parameter int unsigned DW      = FFT_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [LOG2_NS-1:0]   out_index,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  if (NS != (1 << LOG2_NS)) begin : g_bad_ns
    $error("fft_bitrev_framer: NS must equal 2**LOG2_NS");
  end
  if (DW != FFT_DW) begin : g_bad_dw
    $error("fft_bitrev_framer: DW must match fft_pkg::FFT_DW");
  end
  if (LOG2_NS > IDX_MAX_W) begin : g_bad_log2
    $error("fft_bitrev_framer: LOG2_NS exceeds bitrev() index width");
  end

  localparam logic [LOG2_NS-1:0] LAST_CNT = LOG2_NS'(NS - 1);

  logic               wr_bank_q, wr_bank_d;
  logic [LOG2_NS-1:0] wr_cnt_q,  wr_cnt_d;
  logic               rd_bank_q, rd_bank_d;
  logic [LOG2_NS-1:0] rd_cnt_q,  rd_cnt_d;

  logic [1:0]         full;
  cplx_t              rd_data [2];
  cplx_t              rd_sel;
  cplx_t              in_sample;
  logic [LOG2_NS-1:0] rd_addr;
  logic               in_fire, out_fire;
  logic               wr_last, rd_last;

  // Gating with rst_n keeps every output at zero while reset is held,
  // including the very first reset when the flops are still unknown.
  assign in_ready  = rst_n & ~full[wr_bank_q];
  assign out_valid = rst_n &  full[rd_bank_q];

  assign in_fire   = in_valid  & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wr_last   = (wr_cnt_q == LAST_CNT);
  assign rd_last   = (rd_cnt_q == LAST_CNT);
  assign in_sample = {in_re, in_im};
  assign rd_addr   = LOG2_NS'(bitrev(IDX_MAX_W'(rd_cnt_q), LOG2_NS));

  // Counters wrap to 0 on their own after NS-1 because NS is a power of two.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_last) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (out_fire) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_last) begin
        rd_bank_d = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic sel_wr, sel_rd;
    assign sel_wr = (wr_bank_q == 1'(b));
    assign sel_rd = (rd_bank_q == 1'(b));

    fft_pp_bank #(
      .LOG2_NS (LOG2_NS),
      .NS      (NS)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (in_fire & sel_wr),
      .wr_addr  (wr_cnt_q),
      .wr_data  (in_sample),
      .set_full (in_fire & sel_wr & wr_last),
      .clr_full (out_fire & sel_rd & rd_last),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data[b]),
      .full     (full[b])
    );
  end

  assign rd_sel = rd_bank_q ? rd_data[1] : rd_data[0];

  // Data only moves on a transfer, so a stalled output holds by construction.
  always_comb begin
    out_re    = '0;
    out_im    = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_re    = rd_sel.re;
      out_im    = rd_sel.im;
      out_index = rd_addr;
      out_last  = rd_last;
    end
  end

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=>
      (out_valid && $stable({out_re, out_im, out_index, out_last})));

endmodule

// File: tb/tb_fft_bitrev_framer.sv
module tb_fft_bitrev_framer;

  localparam int LOG2_NS = 3;
  localparam int NS      = 8;
  localparam int DW      = 16;

  logic                 clk;
  logic                 rst_n;
  logic signed [DW-1:0] in_re, in_im;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] out_re, out_im;
  logic [LOG2_NS-1:0]   out_index;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;

  fft_bitrev_framer #(.LOG2_NS(LOG2_NS), .NS(NS), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } samp_t;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [LOG2_NS-1:0]   idx;
    logic                 last;
  } exp_t;

  samp_t stim_q[$];
  samp_t frame_buf[$];
  exp_t  sb_q[$];
  int    re_log[$];
  int    idx_log[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int frame_done_cyc;
  int valid_cyc;
  int ready_drops;

  function automatic int rev_idx(int k);
    int r = 0;
    for (int b = 0; b < LOG2_NS; b++) begin
      if ((k & (1 << b)) != 0) r |= 1 << (LOG2_NS - 1 - b);
    end
    return r;
  endfunction

  task automatic push_sample(input int re, input int im);
    samp_t s;
    s.re = DW'(re);
    s.im = DW'(im);
    stim_q.push_back(s);
  endtask

  // Cycle-accurate driver/monitor. Runs at negedges: observe outputs, drive
  // the next inputs, predict which transfers the coming posedge will make.
  task automatic run_stream(input int valid_pct, input int ready_pct,
                            input int max_cycles, input int max_out,
                            input bit timeout_ok);
    int n_cyc = 0;
    int n_out = 0;
    bit fire_in, fire_out;
    bit prev_hold = 1'b0;
    logic signed [DW-1:0] prev_re, prev_im;
    logic [LOG2_NS-1:0]   prev_idx;
    logic                 prev_last;
    exp_t e;
    frame_done_cyc = -1;
    valid_cyc      = -1;
    ready_drops    = 0;
    re_log.delete();
    idx_log.delete();
    while ((stim_q.size() > 0 || sb_q.size() > 0) && n_cyc < max_cycles && n_out < max_out) begin
      if (prev_hold) begin
        total++;
        if (out_valid !== 1'b1 || out_re !== prev_re || out_im !== prev_im ||
            out_index !== prev_idx || out_last !== prev_last) begin
          bad++;
          $display("FAIL hold_stable: got v=%0b re=%0d im=%0d idx=%0d last=%0b, want v=1 re=%0d im=%0d idx=%0d last=%0b",
                   out_valid, out_re, out_im, out_index, out_last, prev_re, prev_im, prev_idx, prev_last);
        end
      end
      if (out_valid === 1'b1 && valid_cyc < 0) valid_cyc = cyc;
      if (stim_q.size() > 0 && in_ready !== 1'b1) ready_drops++;

      if (stim_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
        in_valid = 1'b1;
        in_re    = stim_q[0].re;
        in_im    = stim_q[0].im;
      end else begin
        in_valid = 1'b0;
        in_re    = DW'($urandom);
        in_im    = DW'($urandom);
      end
      out_ready = (int'($urandom_range(99)) < ready_pct);

      fire_in  = in_valid && (in_ready === 1'b1);
      fire_out = (out_valid === 1'b1) && out_ready;

      if (fire_in) begin
        frame_buf.push_back(stim_q.pop_front());
        if (frame_buf.size() == NS) begin
          for (int k = 0; k < NS; k++) begin
            int j;
            j      = rev_idx(k);
            e.re   = frame_buf[j].re;
            e.im   = frame_buf[j].im;
            e.idx  = LOG2_NS'(j);
            e.last = (k == NS - 1);
            sb_q.push_back(e);
          end
          frame_buf.delete();
          if (frame_done_cyc < 0) frame_done_cyc = cyc;
        end
      end

      if (fire_out) begin
        n_out++;
        total++;
        re_log.push_back(int'(out_re));
        idx_log.push_back(int'(out_index));
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: got re=%0d idx=%0d, want no output", out_re, out_index);
        end else begin
          e = sb_q.pop_front();
          if (out_re !== e.re || out_im !== e.im || out_index !== e.idx || out_last !== e.last) begin
            bad++;
            $display("FAIL out_data: got re=%0d im=%0d idx=%0d last=%0b, want re=%0d im=%0d idx=%0d last=%0b",
                     out_re, out_im, out_index, out_last, e.re, e.im, e.idx, e.last);
          end
        end
      end

      prev_hold = (out_valid === 1'b1) && !out_ready;
      prev_re   = out_re;
      prev_im   = out_im;
      prev_idx  = out_index;
      prev_last = out_last;

      @(negedge clk);
      cyc++;
      n_cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (n_cyc >= max_cycles && !timeout_ok) begin
      bad++;
      $display("FAIL stream_timeout: got %0d cycles with %0d pending, want completion", n_cyc, sb_q.size());
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_re     = '0;
    in_im     = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    total += 6;
    if (in_ready  !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    if (out_last  !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %0b want 0", out_last); end
    if (out_index !== '0)   begin bad++; $display("FAIL rst_out_index: got %0d want 0", out_index); end
    if (out_re    !== '0)   begin bad++; $display("FAIL rst_out_re: got %0d want 0", out_re); end
    if (out_im    !== '0)   begin bad++; $display("FAIL rst_out_im: got %0d want 0", out_im); end
    rst_n = 1'b1;
    #1;
    total += 2;
    if (in_ready  !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %0b want 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid: got %0b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int exp_re  [NS] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int exp_idx [NS] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int in_vals [NS] = '{1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < NS; i++) push_sample(in_vals[i], 0);
    run_stream(100, 100, 100, 1 << 30, 1'b0);
    total++;
    if (valid_cyc != frame_done_cyc + 1) begin
      bad++;
      $display("FAIL single_latency: got out_valid at +%0d, want +1", valid_cyc - frame_done_cyc);
    end
    total++;
    if (re_log.size() != NS) begin
      bad++;
      $display("FAIL single_count: got %0d outputs want %0d", re_log.size(), NS);
    end else begin
      for (int i = 0; i < NS; i++) begin
        total++;
        if (re_log[i] != exp_re[i] || idx_log[i] != exp_idx[i]) begin
          bad++;
          $display("FAIL single_order[%0d]: got re=%0d idx=%0d want re=%0d idx=%0d",
                   i, re_log[i], idx_log[i], exp_re[i], exp_idx[i]);
        end
      end
    end
  endtask

  task automatic test_ramp_stream();
    int exp_f1 [NS] = '{8, 12, 10, 14, 9, 13, 11, 15};
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < NS; i++) push_sample(f * NS + i, -(f * NS + i));
    run_stream(100, 100, 200, 1 << 30, 1'b0);
    total++;
    if (ready_drops != 0) begin
      bad++;
      $display("FAIL ramp_in_ready: got %0d stalled cycles want 0", ready_drops);
    end
    for (int i = 0; i < NS; i++) begin
      total++;
      if (re_log.size() != 4 * NS || re_log[NS + i] != exp_f1[i]) begin
        bad++;
        $display("FAIL ramp_frame1[%0d]: got %0d want %0d", i,
                 (re_log.size() > NS + i) ? re_log[NS + i] : -1, exp_f1[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3 * NS; i++) push_sample(200 + i, 300 - i);
    run_stream(100, 0, 30, 1 << 30, 1'b1);
    total += 4;
    if (stim_q.size() != NS) begin
      bad++;
      $display("FAIL bp_accepted: got %0d want %0d", 3 * NS - stim_q.size(), 2 * NS);
    end
    if (in_ready  !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
    if (out_re !== DW'(200) || out_index !== '0) begin
      bad++;
      $display("FAIL bp_head: got re=%0d idx=%0d want re=200 idx=0", out_re, out_index);
    end
    run_stream(0, 100, 50, NS, 1'b0);
    total += 2;
    if (re_log.size() != NS) begin bad++; $display("FAIL bp_drained: got %0d want %0d", re_log.size(), NS); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got in_ready=%0b want 1", in_ready); end
    run_stream(100, 100, 200, 1 << 30, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 100 * NS; i++) push_sample(int'($urandom_range(65535)), int'($urandom_range(65535)));
    run_stream(70, 50, 20000, 1 << 30, 1'b0);
    total++;
    if (sb_q.size() != 0 || frame_buf.size() != 0) begin
      bad++;
      $display("FAIL random_leftover: got sb=%0d partial=%0d want 0 0", sb_q.size(), frame_buf.size());
    end
  endtask

  task automatic test_reset_mid();
    int exp_idx [NS] = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < NS + 5; i++) push_sample(50 + i, 60 + i);
    run_stream(100, 0, 20, 1 << 30, 1'b1);
    rst_n = 1'b0;
    stim_q.delete();
    frame_buf.delete();
    sb_q.delete();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0b want 0", out_valid); end
    rst_n = 1'b1;
    #1;
    total += 2;
    if (in_ready  !== 1'b1) begin bad++; $display("FAIL mid_rel_ready: got %0b want 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_valid: got %0b want 0", out_valid); end
    @(negedge clk);
    for (int i = 0; i < NS; i++) push_sample(100 + i, -100 - i);
    run_stream(100, 100, 100, 1 << 30, 1'b0);
    for (int i = 0; i < NS; i++) begin
      total++;
      if (re_log.size() != NS || re_log[i] != 100 + exp_idx[i]) begin
        bad++;
        $display("FAIL mid_clean[%0d]: got %0d want %0d", i,
                 (re_log.size() > i) ? re_log[i] : -1, 100 + exp_idx[i]);
      end
    end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < NS; i++) push_sample(-32768, 32767);
    run_stream(100, 100, 100, 1 << 30, 1'b0);
    total++;
    if (re_log.size() != NS) begin
      bad++;
      $display("FAIL extreme_count: got %0d want %0d", re_log.size(), NS);
    end
    foreach (re_log[i]) begin
      total++;
      if (re_log[i] != -32768) begin
        bad++;
        $display("FAIL extreme_re[%0d]: got %0d want -32768", i, re_log[i]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_re     = '0;
    in_im     = '0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_ramp_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
